// File: rtl/uart_bist_pkg.sv
// Shared types and constants for the UART loopback built-in self-test.
package uart_bist_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    CHECK,
    NEXT,
    FINISH
  } bist_state_t;

  typedef enum logic {
    INCR = 1'b0,
    LFSR = 1'b1
  } bist_mode_t;

  localparam logic [BYTE_W-1:0] LFSR_TAPS     = 8'hB8;
  localparam logic [BYTE_W-1:0] LFSR_ZERO_SUB = 8'h01;

  // One step of the right-shifting Galois LFSR (x^8+x^6+x^5+x^4+1).
  function automatic logic [BYTE_W-1:0] lfsr_step(input logic [BYTE_W-1:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/uart_bist_pattern.sv
// Expected-byte generator: loads a seed, then steps an incrementing or LFSR sequence.
module uart_bist_pattern
  import uart_bist_pkg::*;
(
  input  logic              clk,
  input  logic              nReset,
  input  logic              load,
  input  logic              advance,
  input  bist_mode_t        mode,
  input  logic [BYTE_W-1:0] seed,
  output logic [BYTE_W-1:0] expected
);

  bist_mode_t mode_q;

  // An all-zero seed would lock the LFSR, so it is replaced on load.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      expected <= '0;
      mode_q   <= INCR;
    end else if (load) begin
      mode_q   <= mode;
      expected <= (mode == LFSR && seed == '0) ? LFSR_ZERO_SUB : seed;
    end else if (advance) begin
      expected <= (mode_q == LFSR) ? lfsr_step(expected) : expected + BYTE_W'(1);
    end
  end

endmodule

// File: rtl/uart_loopback_bist.sv
// BIST controller for the UART loopback path: sends a byte pattern, checks the echo,
// and reports pass / error count / timeout per run.
module uart_loopback_bist
  import uart_bist_pkg::*;
#(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic              mode,
  input  logic [BYTE_W-1:0] seed,
  input  logic [CNT_W-1:0]  numBytes,
  output logic [BYTE_W-1:0] data_tx,
  output logic              valid,
  input  logic              busy,
  input  logic              done_tx,
  input  logic [BYTE_W-1:0] data_rx,
  input  logic              done_rx,
  input  logic              err,
  output logic              active,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  errCount,
  output logic              timeout
);

  localparam int unsigned      TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bist_state_t       state, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              tx_seen_q, tx_seen_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_err_q, rx_err_d;
  logic              valid_d, active_d, done_d, pass_d, timeout_d;
  logic [CNT_W-1:0]  err_cnt_d;
  logic              load_c, advance_c;

  uart_bist_pattern u_pattern (
    .clk      (clk),
    .nReset   (nReset),
    .load     (load_c),
    .advance  (advance_c),
    .mode     (bist_mode_t'(mode)),
    .seed     (seed),
    .expected (data_tx)
  );

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state       <= IDLE;
      remaining_q <= '0;
      to_cnt_q    <= '0;
      tx_seen_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_err_q    <= 1'b0;
      valid       <= 1'b0;
      active      <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      errCount    <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      remaining_q <= remaining_d;
      to_cnt_q    <= to_cnt_d;
      tx_seen_q   <= tx_seen_d;
      rx_data_q   <= rx_data_d;
      rx_err_q    <= rx_err_d;
      valid       <= valid_d;
      active      <= active_d;
      done        <= done_d;
      pass        <= pass_d;
      errCount    <= err_cnt_d;
      timeout     <= timeout_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    remaining_d = remaining_q;
    to_cnt_d    = to_cnt_q;
    tx_seen_d   = tx_seen_q;
    rx_data_d   = rx_data_q;
    rx_err_d    = rx_err_q;
    valid_d     = valid;
    active_d    = active;
    done_d      = 1'b0;
    pass_d      = pass;
    err_cnt_d   = errCount;
    timeout_d   = timeout;
    load_c      = 1'b0;
    advance_c   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          load_c      = 1'b1;
          remaining_d = (numBytes == '0) ? CNT_W'(1) : numBytes;
          err_cnt_d   = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          tx_seen_d   = 1'b0;
          valid_d     = 1'b1;
          active_d    = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (done_tx) tx_seen_d = 1'b1;
        if (busy) begin
          valid_d  = 1'b0;
          to_cnt_d = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (done_tx) tx_seen_d = 1'b1;
        if (done_rx) begin
          rx_data_d = data_rx;
          rx_err_d  = err;
          state_d   = CHECK;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      // The frame is only judged once the transmitter has also finished it.
      CHECK: begin
        if (tx_seen_q || done_tx) begin
          if ((rx_err_q || rx_data_q != data_tx) && errCount != CNT_MAX) begin
            err_cnt_d = errCount + CNT_W'(1);
          end
          state_d = NEXT;
        end
      end
      NEXT: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = FINISH;
        end else begin
          advance_c = 1'b1;
          tx_seen_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = SEND;
        end
      end
      FINISH: begin
        pass_d   = (errCount == '0) && !timeout;
        done_d   = 1'b1;
        active_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Scoreboard bench for uart_loopback_bist with a behavioural UART loopback model.
module tb_uart_loopback_bist;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO    = 64;

  logic             clk = 1'b0;
  logic             nReset, start, mode;
  logic [7:0]       seed;
  logic [CNT_W-1:0] numBytes;
  logic [7:0]       data_tx;
  logic             valid, busy, done_tx;
  logic [7:0]       data_rx;
  logic             done_rx, err, active, done, pass, timeout;
  logic [CNT_W-1:0] errCount;

  always #5 clk = ~clk;

  uart_loopback_bist #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nReset(nReset), .start(start), .mode(mode), .seed(seed),
    .numBytes(numBytes), .data_tx(data_tx), .valid(valid), .busy(busy),
    .done_tx(done_tx), .data_rx(data_rx), .done_rx(done_rx), .err(err),
    .active(active), .done(done), .pass(pass), .errCount(errCount), .timeout(timeout)
  );

  typedef struct {
    logic p;
    int   e;
    logic t;
  } res_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_bytes[$];
  res_t       exp_res[$];

  // Loopback corruption controls for the current run.
  int flip_idx = -1;
  int ferr_idx = -1;
  bit dead     = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] next_pat(input logic m, input logic [7:0] v);
    if (!m) return v + 8'd1;
    return (v % 2 == 1) ? ((v / 2) ^ 8'd184) : (v / 2);
  endfunction

  // Loopback model: accepts a byte on valid, then pulses done_tx and done_rx.
  initial begin
    int phase, cnt, t_tx, t_rx, idx;
    logic [7:0] cur;
    phase = 0; cnt = 0; t_tx = 0; t_rx = 0; idx = 0; cur = 8'h00;
    busy = 1'b0; done_tx = 1'b0; done_rx = 1'b0; err = 1'b0; data_rx = 8'h00;
    forever begin
      @(negedge clk);
      done_tx = 1'b0;
      done_rx = 1'b0;
      err     = 1'b0;
      if (!nReset) begin
        phase = 0;
        busy  = 1'b0;
        idx   = 0;
      end else if (phase == 0) begin
        if (!active) idx = 0;
        if (valid) begin
          cur   = data_tx;
          busy  = 1'b1;
          phase = 1;
          cnt   = 0;
          t_tx  = int'($urandom_range(6, 20));
          t_rx  = t_tx + int'($urandom_range(0, 4)) - 2;
        end
      end else begin
        cnt++;
        if (cnt == t_tx) begin
          busy    = 1'b0;
          done_tx = 1'b1;
        end
        if (cnt == t_rx && !dead) begin
          done_rx = 1'b1;
          data_rx = (idx == flip_idx) ? (cur ^ 8'h01) : cur;
          err     = (idx == ferr_idx);
        end
        if (cnt >= t_tx && cnt >= t_rx) begin
          phase = 0;
          idx++;
        end
      end
    end
  end

  // Monitor: checks each transmitted byte and each end-of-run report.
  initial begin
    logic vprev;
    res_t r;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && !vprev) begin
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_byte: unexpected byte 0x%0h at %0t", data_tx, $time);
        end else begin
          chk("tx_byte", int'(data_tx), int'(exp_bytes.pop_front()));
        end
      end
      vprev = (valid === 1'b1);
      if (done === 1'b1) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_pulse: unexpected done at %0t", $time);
        end else begin
          r = exp_res.pop_front();
          chk("pass", int'(pass), int'(r.p));
          chk("errCount", int'(errCount), r.e);
          chk("timeout", int'(timeout), int'(r.t));
          chk("active_at_done", int'(active), 0);
          chk("valid_at_done", int'(valid), 0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_data_tx"}, int'(data_tx), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_errCount"}, int'(errCount), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  // Queue the expected bytes and report for a run, then pulse start.
  task automatic launch(input logic m, input logic [7:0] s, input int n,
                        input int fi, input int fe, input bit d);
    logic [7:0] v;
    int nn, ec;
    res_t r;
    flip_idx = fi;
    ferr_idx = fe;
    dead     = d;
    nn = (n == 0) ? 1 : n;
    v  = (m && s == 8'h00) ? 8'h01 : s;
    ec = 0;
    for (int i = 0; i < nn; i++) begin
      if (d && i > 0) break;
      exp_bytes.push_back(v);
      if (!d && (i == fi || i == fe)) ec++;
      v = next_pat(m, v);
    end
    r.p = (ec == 0) && !d;
    r.e = (ec > 255) ? 255 : ec;
    r.t = d;
    exp_res.push_back(r);
    mode = m; seed = s; numBytes = CNT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    seed     = 8'($urandom);
    numBytes = CNT_W'($urandom);
    mode     = 1'($urandom);
    chk("valid_after_start", int'(valid), 1);
    chk("active_after_start", int'(active), 1);
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(done === 1'b1), 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, falls;
    logic vp;
    nReset = 1'b0; start = 1'b0; mode = 1'b0; seed = 8'h00; numBytes = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nReset = 1'b1;
    @(negedge clk);

    launch(1'b0, 8'h10, 4, -1, -1, 1'b0);
    wait_done("incr_run");

    launch(1'b1, 8'h00, 3, -1, -1, 1'b0);
    wait_done("lfsr_run");

    launch(1'b0, 8'($urandom), 5, 1, -1, 1'b0);
    wait_done("flip_run");

    launch(1'($urandom), 8'($urandom), 5, 1, 3, 1'b0);
    wait_done("flip_ferr_run");

    // Dead receiver: timeout must assert exactly TO cycles after valid drops.
    launch(1'b1, 8'h5A, 3, -1, -1, 1'b1);
    k = 0;
    while (valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!timeout && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", k, int'(TO));
    wait_done("dead_run");
    dead = 1'b0;

    // Start pulses during a run must be ignored.
    launch(1'b0, 8'h40, 6, -1, -1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (7 + p * 5) @(negedge clk);
      seed = 8'hEE; numBytes = CNT_W'(9); mode = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("mid_start_run");

    launch(1'($urandom), 8'($urandom), 0, -1, -1, 1'b0);
    wait_done("zero_count_run");

    // Reset during WAIT of the second byte.
    launch(1'b0, 8'h80, 4, -1, -1, 1'b0);
    falls = 0;
    vp = 1'b1;
    k = 0;
    while (falls < 2 && k < 500) begin
      @(negedge clk);
      if (vp && !valid) falls++;
      vp = valid;
      k++;
    end
    chk("reach_byte2_wait", falls, 2);
    @(negedge clk);
    nReset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    repeat (2) begin
      @(negedge clk);
      chk("no_done_in_reset", int'(done), 0);
    end
    exp_bytes.delete();
    exp_res.delete();
    nReset = 1'b1;
    @(negedge clk);
    launch(1'($urandom), 8'($urandom), 3, -1, -1, 1'b0);
    wait_done("post_reset_run");

    repeat (8) begin
      logic m;
      int n, fi, fe;
      m  = 1'($urandom);
      n  = int'($urandom_range(1, 6));
      fi = ($urandom % 3 == 0) ? int'($urandom_range(0, n - 1)) : -1;
      fe = ($urandom % 3 == 0) ? int'($urandom_range(0, n - 1)) : -1;
      launch(m, 8'($urandom), n, fi, fe, 1'b0);
      wait_done("random_run");
    end

    chk("bytes_drained", exp_bytes.size(), 0);
    chk("results_drained", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_loopback_bist.md
# uart_loopback_bist

Built-in self-test controller for the UART loopback datapath (BaudRateGen + UartTxEn + UartRxEn, TX output wired to RX input). On `start`, it generates a programmable byte sequence, hands each byte to the transmitter, and waits for the matching receive event. It compares received data against expected data and reports pass/fail, an error count and a timeout flag. It sits beside the loopback harness in place of the free-running `valid`/`data_tx` stimulus.

## Interface
- `CNT_W`, default 8: width of byte-count and error-count fields.
- `TIMEOUT_CYCLES`, default 4096: max clk cycles to wait for `done_rx` per byte; must be ≥ 2 UART frame times at the configured rate.
- `clk`  in  1  system clock; all logic rising-edge.
- `nReset`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a run; ignored unless idle.
- `mode`  in  1  0 = incrementing pattern, 1 = LFSR pattern.
- `seed`  in  8  first pattern byte; sampled on accepted `start`.
- `numBytes`  in  CNT_W  bytes per run; sampled on accepted `start`; 0 treated as 1.
- `data_tx`  out  8  byte to transmitter.
- `valid`  out  1  transmit request to UartTxEn.
- `busy`  in  1  transmitter busy.
- `done_tx`  in  1  transmitter frame-complete pulse.
- `data_rx`  in  8  received byte.
- `done_rx`  in  1  receiver byte-complete pulse.
- `err`  in  1  receiver framing error, qualified by `done_rx`.
- `active`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  last run had zero errors and no timeout; held until next accepted `start`.
- `errCount`  out  CNT_W  mismatches + framing errors in last/current run; saturates at all-ones.
- `timeout`  out  1  last run aborted on timeout; held until next accepted `start`.

## Operation
- States: IDLE, SEND, WAIT, CHECK, NEXT, FINISH.
- IDLE: `start`=1 → latch `seed`/`numBytes`/`mode`, clear `errCount`/`pass`/`timeout`, expected ← seed (seed 0 in LFSR mode replaced by 0x01), remaining ← numBytes, go to SEND.
- SEND: drive `valid`=1, `data_tx`=expected. When `busy`=1 is sampled, drop `valid` next cycle and go to WAIT. `data_tx` holds stable from SEND entry until leaving CHECK.
- WAIT: timeout counter runs from 0. `done_rx`=1 → capture `data_rx`/`err` and go to CHECK. `done_tx` is tracked with a sticky flag; CHECK also requires it. If counter reaches TIMEOUT_CYCLES-1 with no `done_rx` → set `timeout`, go to FINISH.
- CHECK: wait for `done_tx` flag (or its same-cycle pulse). Error if `err`=1 or captured byte ≠ expected; increment `errCount` (saturating). Go to NEXT.
- NEXT: remaining−1. If 0 → FINISH. Otherwise advance the pattern and go to SEND. Incrementing: expected+1 mod 256. LFSR: Galois, polynomial x^8+x^6+x^5+x^4+1, taps 0xB8, shift right.
- FINISH: `pass` ← (errCount==0 && !timeout), pulse `done`, go to IDLE.
- `start` while not IDLE is ignored.
- Reset mid-run: all state returns to reset values next edge. Any frame in flight in the datapath is abandoned; no `done` pulse.

## Timing
- Reset values: `valid`=0, `data_tx`=0x00, `active`=0, `done`=0, `pass`=0, `errCount`=0, `timeout`=0, state IDLE.
- `start` at cycle N → `valid`=1 and `active`=1 at N+1.
- `active` deasserts in the same cycle `done` pulses.
- `done_rx` and `done_tx` in the same cycle: legal, both consumed.
- `done_rx` in the same cycle `valid` drops: legal.
- Minimum inter-byte gap after CHECK: 2 cycles (NEXT, SEND).
- Timeout counter width is $clog2(TIMEOUT_CYCLES). It resets on every WAIT entry.

## Structure
- Package `uart_bist_pkg`: state enum `bist_state_t`, mode enum `bist_mode_t` (INCR, LFSR), constant `LFSR_TAPS` = 8'hB8, constant `LFSR_ZERO_SUB` = 8'h01.
- Sub-module `uart_bist_pattern`: holds expected byte; load/advance inputs, mode select; pure pattern generator.
- Top is FSM + timeout counter + error counter.

## Test plan
- Clean incrementing run on real loopback (rate 2<<4): seed 0x10, numBytes 4 → bytes 0x10..0x13 sent in order, `done` once, `pass`=1, `errCount`=0.
- LFSR run: seed 0x00, numBytes 3 → `data_tx` sequence 0x01, 0xB8, 0x5C; `pass`=1.
- Corruption model: RX byte bit 0 flipped on 2nd of 5 bytes → `errCount`=1, `pass`=0; framing `err` on 4th byte also → `errCount`=2.
- Dead RX (`done_rx` tied 0), TIMEOUT_CYCLES=64 → `timeout`=1 after 64 WAIT cycles, `done` pulse, `pass`=0, `valid`=0.
- `start` pulsed mid-run, and `numBytes`=0 → second `start` ignored; zero-count run sends exactly 1 byte.
- `nReset` low during WAIT of byte 2 → next cycle all outputs at reset values, no `done`; fresh run then passes.
